// File: rtl/cf_map_pkg.sv
// ============================================================================
// Module  : cf_map_pkg
// Brief   : Shared fold-mode encodings and digit-count helper for the mapper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cf_map_pkg;

    localparam logic MAP_SUM = 1'b0;
    localparam logic MAP_XOR = 1'b1;

    // Number of bank-width digits covering an address, top digit may be partial.
    function automatic int cf_num_digits(input int addr_w, input int bank_w);
        return (addr_w + bank_w - 1) / bank_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cf_map_lane.sv
// ============================================================================
// Module  : cf_map_lane
// Brief   : Combinational per-lane bank fold (digit sum or digit XOR) and row.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cf_map_lane
    import cf_map_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int BANK_W = 2
) (
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     mode,
    output logic [BANK_W-1:0]        bank,
    output logic [ADDR_W-BANK_W-1:0] row
);

    localparam int c_digits = cf_num_digits(ADDR_W, BANK_W);
    localparam int c_ext_w  = c_digits * BANK_W;

    logic [c_ext_w-1:0] w_ext;
    logic [BANK_W-1:0]  w_sum;
    logic [BANK_W-1:0]  w_xor;

    assign w_ext = c_ext_w'(addr);

    // Sum is kept at BANK_W bits so carries out of the bank index drop naturally.
    always_comb begin
        w_sum = '0;
        w_xor = '0;
        for (int d = 0; d < c_digits; d++) begin
            w_sum = w_sum + w_ext[d*BANK_W +: BANK_W];
            w_xor = w_xor ^ w_ext[d*BANK_W +: BANK_W];
        end
    end

    assign bank = (mode == MAP_XOR) ? w_xor : w_sum;
    assign row  = addr[ADDR_W-1:BANK_W];

endmodule

`default_nettype wire

// File: rtl/conflict_free_bank_mapper.sv
// ============================================================================
// Module  : conflict_free_bank_mapper
// Brief   : Two-stage multi-lane address-to-bank mapper with conflict counting.
// Revision: 1.0
// ============================================================================
`default_nettype none

module conflict_free_bank_mapper
    import cf_map_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int BANK_W = 2,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANES*ADDR_W-1:0]           in_addr,
    input  logic                              mode,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES*BANK_W-1:0]           out_bank,
    output logic [LANES*(ADDR_W-BANK_W)-1:0]  out_addr,
    output logic                              out_conflict,
    output logic [CNT_W-1:0]                  conflict_cnt
);

    localparam int              c_row_w   = ADDR_W - BANK_W;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [LANES*BANK_W-1:0]  w_bank;
    logic [LANES*c_row_w-1:0] w_row;
    logic                     w_s2_adv;
    logic                     w_in_ready;
    logic                     w_conflict;

    logic                     r_s1_valid;
    logic [LANES*BANK_W-1:0]  r_s1_bank;
    logic [LANES*c_row_w-1:0] r_s1_row;
    logic                     r_s2_valid;
    logic [LANES*BANK_W-1:0]  r_s2_bank;
    logic [LANES*c_row_w-1:0] r_s2_row;
    logic                     r_s2_conflict;
    logic [CNT_W-1:0]         r_cnt;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            cf_map_lane #(
                .ADDR_W (ADDR_W),
                .BANK_W (BANK_W)
            ) u_lane (
                .addr (in_addr[k*ADDR_W +: ADDR_W]),
                .mode (mode),
                .bank (w_bank[k*BANK_W +: BANK_W]),
                .row  (w_row[k*c_row_w +: c_row_w])
            );
        end
    endgenerate

    assign w_s2_adv   = !r_s2_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_adv;

    // Pairwise compare; the loop body never runs for a single lane.
    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (r_s1_bank[i*BANK_W +: BANK_W] == r_s1_bank[j*BANK_W +: BANK_W]) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_bank     <= '0;
            r_s1_row      <= '0;
            r_s2_valid    <= 1'b0;
            r_s2_bank     <= '0;
            r_s2_row      <= '0;
            r_s2_conflict <= 1'b0;
            r_cnt         <= '0;
        end else begin
            if (w_in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_bank <= w_bank;
                    r_s1_row  <= w_row;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_bank     <= r_s1_bank;
                    r_s2_row      <= r_s1_row;
                    r_s2_conflict <= w_conflict;
                end
            end
            if (r_s2_valid && out_ready && r_s2_conflict && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_s2_valid;
    assign out_bank     = r_s2_bank;
    assign out_addr     = r_s2_row;
    assign out_conflict = r_s2_conflict;
    assign conflict_cnt = r_cnt;

endmodule

`default_nettype wire
